// File: rtl/shift_pkg.sv
// Shared encodings for the multi-cycle shift unit: operation codes, FSM state
// constants and a small arithmetic helper.
package shift_pkg;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  typedef logic [1:0] shift_state_t;

  localparam shift_state_t ST_IDLE  = 2'd0;
  localparam shift_state_t ST_SHIFT = 2'd1;
  localparam shift_state_t ST_DONE  = 2'd2;

  function automatic logic [31:0] umin32(input logic [31:0] a, input logic [31:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/shift_seq_unit_if.sv
// Launch/result bundle between the decoder/execute stage and shift_seq_unit.
interface shift_seq_unit_if #(
  parameter int DATA_W = 32,
  parameter int AMT_W  = 8
);
  logic              start;
  logic [1:0]        op;
  logic              s_flag;
  logic [DATA_W-1:0] rm;
  logic [AMT_W-1:0]  amount;
  logic              carry_in;
  logic              zero_in;
  logic              neg_in;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rd;
  logic              carry_out;
  logic              zero_out;
  logic              neg_out;

  modport master (
    output start, op, s_flag, rm, amount, carry_in, zero_in, neg_in,
    input  busy, done, rd, carry_out, zero_out, neg_out
  );

  modport slave (
    input  start, op, s_flag, rm, amount, carry_in, zero_in, neg_in,
    output busy, done, rd, carry_out, zero_out, neg_out
  );
endinterface

// File: rtl/shift_step.sv
// One combinational shift step of k (<= STEP) bits, returning the last bit out.
// The rotate path exists only when SHIFT_ROR_EN is defined.
module shift_step
  import shift_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int K_W    = 1
) (
  input  logic [DATA_W-1:0] data,
  input  logic [1:0]        op,
  input  logic              fill,
  input  logic [K_W-1:0]    k,
  output logic [DATA_W-1:0] result,
  output logic              last_out
);

  logic [DATA_W:0]   left_s;
  logic [DATA_W:0]   right_s;
  logic [DATA_W-1:0] hi_s;

  // Right shifts run through {hi, data, guard}; the guard slot catches the last bit out.
  always_comb begin
`ifdef SHIFT_ROR_EN
    hi_s = (op == SH_ROR) ? data : {DATA_W{fill}};
`else
    hi_s = {DATA_W{fill}};
`endif
    left_s  = {1'b0, data} << k;
    right_s = (DATA_W + 1)'({hi_s, data, 1'b0} >> k);
    if (op == SH_LSL) begin
      result   = left_s[DATA_W-1:0];
      last_out = left_s[DATA_W];
    end else begin
      result   = right_s[DATA_W:1];
      last_out = right_s[0];
    end
  end

endmodule

// File: rtl/shift_seq_unit.sv
// Multi-cycle LSL/LSR/ASR(/ROR) unit with start/busy/done handshake and NZC update.
// Build option: SHIFT_ROR_EN enables the rotate-right operation for op=11.
module shift_seq_unit
  import shift_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int AMT_W  = 8,
  parameter int STEP   = 1
) (
  input  logic            clk,
  input  logic            rst,
  shift_seq_unit_if.slave bus
);

  localparam int CNT_W = $clog2(DATA_W + 2);
  localparam int K_W   = $clog2(STEP + 1);
  localparam int MSB   = DATA_W - 1;

  shift_state_t      state_r;
  shift_state_t      state_nxt_s;
  logic [DATA_W-1:0] data_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [1:0]        op_r;
  logic              s_flag_r;
  logic              carry_in_r;
  logic              zero_in_r;
  logic              neg_in_r;
  logic              sign_r;
  logic              busy_r;
  logic              done_r;
  logic [DATA_W-1:0] rd_r;
  logic              carry_out_r;
  logic              zero_out_r;
  logic              neg_out_r;

  logic              accept_s;
  logic [AMT_W-1:0]  amount_s;
  logic [31:0]       amt_ext_s;
  logic [31:0]       eff_cnt_ext_s;
  logic [CNT_W-1:0]  cnt_load_s;
  logic              ror_wrap_s;
  logic              carry_init_s;
  logic              s_eff_s;
  logic [K_W-1:0]    k_s;
  logic              last_step_s;
  logic              fill_s;
  logic [DATA_W-1:0] step_data_s;
  logic              step_last_s;
  logic              load_out_s;
  logic [DATA_W-1:0] fin_data_s;
  logic              fin_c_s;
  logic              fin_s_s;
  logic              fin_cin_s;
  logic              fin_zin_s;
  logic              fin_nin_s;
  logic              nxt_c_s;
  logic              nxt_z_s;
  logic              nxt_n_s;

  assign amount_s = bus.amount;

  // Launch decode: effective count and the carry seen when no bit is shifted.
  always_comb begin
    accept_s      = bus.start && (state_r != ST_SHIFT);
    amt_ext_s     = 32'(amount_s);
    eff_cnt_ext_s = 32'd0;
    ror_wrap_s    = 1'b0;
    s_eff_s       = bus.s_flag;
    case (bus.op)
      SH_LSL, SH_LSR: eff_cnt_ext_s = umin32(amt_ext_s, 32'(DATA_W + 1));
      SH_ASR:         eff_cnt_ext_s = umin32(amt_ext_s, 32'(DATA_W));
      SH_ROR: begin
`ifdef SHIFT_ROR_EN
        eff_cnt_ext_s = amt_ext_s & 32'(DATA_W - 1);
        ror_wrap_s    = (amt_ext_s != 32'd0) && (eff_cnt_ext_s == 32'd0);
`else
        eff_cnt_ext_s = 32'd0;
        s_eff_s       = 1'b0;
`endif
      end
      default:        eff_cnt_ext_s = 32'd0;
    endcase
    cnt_load_s   = CNT_W'(eff_cnt_ext_s);
    carry_init_s = ror_wrap_s ? bus.rm[MSB] : bus.carry_in;
  end

  // Per-cycle step size and fill bit for the active operation.
  always_comb begin
    k_s         = (32'(cnt_r) > 32'(STEP)) ? K_W'(STEP) : K_W'(cnt_r);
    last_step_s = (32'(cnt_r) <= 32'(STEP));
    fill_s      = (op_r == SH_ASR) ? sign_r : 1'b0;
  end

  shift_step #(
    .DATA_W (DATA_W),
    .K_W    (K_W)
  ) u_step (
    .data     (data_r),
    .op       (op_r),
    .fill     (fill_s),
    .k        (k_s),
    .result   (step_data_s),
    .last_out (step_last_s)
  );

  // Result source: final shift step, or the operand itself for zero-count launches.
  always_comb begin
    if (state_r == ST_SHIFT) begin
      load_out_s = last_step_s;
      fin_data_s = step_data_s;
      fin_c_s    = step_last_s;
      fin_s_s    = s_flag_r;
      fin_cin_s  = carry_in_r;
      fin_zin_s  = zero_in_r;
      fin_nin_s  = neg_in_r;
    end else begin
      load_out_s = accept_s && (cnt_load_s == {CNT_W{1'b0}});
      fin_data_s = bus.rm;
      fin_c_s    = carry_init_s;
      fin_s_s    = s_eff_s;
      fin_cin_s  = bus.carry_in;
      fin_zin_s  = bus.zero_in;
      fin_nin_s  = bus.neg_in;
    end
    if (fin_s_s) begin
      nxt_n_s = fin_data_s[MSB];
      nxt_z_s = (fin_data_s == {DATA_W{1'b0}});
      nxt_c_s = fin_c_s;
    end else begin
      nxt_n_s = fin_nin_s;
      nxt_z_s = fin_zin_s;
      nxt_c_s = fin_cin_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (accept_s) begin
          state_nxt_s = (cnt_load_s == {CNT_W{1'b0}}) ? ST_DONE : ST_SHIFT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (last_step_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_SHIFT;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM state with registered busy/done decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s == ST_SHIFT);
      done_r  <= (state_nxt_s == ST_DONE);
    end
  end

  // Operand capture on launch, then the working value and count advance each step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_r     <= {DATA_W{1'b0}};
      cnt_r      <= {CNT_W{1'b0}};
      op_r       <= SH_LSL;
      s_flag_r   <= 1'b0;
      carry_in_r <= 1'b0;
      zero_in_r  <= 1'b0;
      neg_in_r   <= 1'b0;
      sign_r     <= 1'b0;
    end else if (accept_s) begin
      data_r     <= bus.rm;
      cnt_r      <= cnt_load_s;
      op_r       <= bus.op;
      s_flag_r   <= s_eff_s;
      carry_in_r <= bus.carry_in;
      zero_in_r  <= bus.zero_in;
      neg_in_r   <= bus.neg_in;
      sign_r     <= bus.rm[MSB];
    end else if (state_r == ST_SHIFT) begin
      data_r <= step_data_s;
      cnt_r  <= cnt_r - CNT_W'(k_s);
    end
  end

  // Result and flags update only on the edge entering DONE, then hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_r        <= {DATA_W{1'b0}};
      carry_out_r <= 1'b0;
      zero_out_r  <= 1'b0;
      neg_out_r   <= 1'b0;
    end else if (load_out_s) begin
      rd_r        <= fin_data_s;
      carry_out_r <= nxt_c_s;
      zero_out_r  <= nxt_z_s;
      neg_out_r   <= nxt_n_s;
    end
  end

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.rd        = rd_r;
  assign bus.carry_out = carry_out_r;
  assign bus.zero_out  = zero_out_r;
  assign bus.neg_out   = neg_out_r;

endmodule

// File: tb/tb_shift_seq_unit.sv
// Bench for shift_seq_unit: STEP=1 and STEP=4 instances run the same stream and are
// checked against an arithmetic reference model (ROR expectations follow SHIFT_ROR_EN).
module tb_shift_seq_unit;
  import shift_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [31:0] o_rd  [2];
  logic        o_c   [2];
  logic        o_z   [2];
  logic        o_n   [2];
  int          o_lat [2];

  shift_seq_unit_if #(.DATA_W(32), .AMT_W(8)) b1 ();
  shift_seq_unit_if #(.DATA_W(32), .AMT_W(8)) b4 ();

  shift_seq_unit #(.DATA_W(32), .AMT_W(8), .STEP(1)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));
  shift_seq_unit #(.DATA_W(32), .AMT_W(8), .STEP(4)) dut4 (.clk(clk), .rst(rst), .bus(b4.slave));

  always #5 clk = ~clk;

  // Reference: result, flags and effective count from the architectural rules.
  function automatic void model(input logic [1:0] op, input logic s, input logic [31:0] rm,
                                input logic [7:0] amt, input logic cin, input logic zin, input logic nin,
                                output logic [31:0] rd, output logic c, output logic z, output logic n,
                                output int cnt);
    int a;
    int m;
    logic use_s;
    a = int'(amt);
    rd = rm; c = cin; cnt = 0; use_s = s;
    case (op)
      SH_LSL: begin
        cnt = (a > 33) ? 33 : a;
        if (a > 0 && a < 32) begin rd = rm << a; c = rm[32 - a]; end
        else if (a == 32) begin rd = 32'd0; c = rm[0]; end
        else if (a > 32) begin rd = 32'd0; c = 1'b0; end
      end
      SH_LSR: begin
        cnt = (a > 33) ? 33 : a;
        if (a > 0 && a < 32) begin rd = rm >> a; c = rm[a - 1]; end
        else if (a == 32) begin rd = 32'd0; c = rm[31]; end
        else if (a > 32) begin rd = 32'd0; c = 1'b0; end
      end
      SH_ASR: begin
        cnt = (a > 32) ? 32 : a;
        if (a > 0 && a < 32) begin rd = 32'($signed(rm) >>> a); c = rm[a - 1]; end
        else if (a >= 32) begin rd = {32{rm[31]}}; c = rm[31]; end
      end
      default: begin
`ifdef SHIFT_ROR_EN
        m = a % 32;
        cnt = m;
        if (m != 0) begin rd = (rm >> m) | (rm << (32 - m)); c = rd[31]; end
        else if (a != 0) c = rm[31];
`else
        m = 0;
        use_s = 1'b0;
`endif
      end
    endcase
    if (use_s) begin n = rd[31]; z = (rd == 32'd0); end
    else begin c = cin; z = zin; n = nin; end
  endfunction

  task automatic drive(input logic st, input logic [1:0] op, input logic s, input logic [31:0] rm,
                       input logic [7:0] amt, input logic cin, input logic zin, input logic nin);
    b1.start = st; b1.op = op; b1.s_flag = s; b1.rm = rm; b1.amount = amt;
    b1.carry_in = cin; b1.zero_in = zin; b1.neg_in = nin;
    b4.start = st; b4.op = op; b4.s_flag = s; b4.rm = rm; b4.amount = amt;
    b4.carry_in = cin; b4.zero_in = zin; b4.neg_in = nin;
  endtask

  task automatic drive_junk(input logic st);
    drive(st, 2'($urandom), 1'($urandom), $urandom, 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
  endtask

  function automatic logic [7:0] pick_amt();
    case ($urandom_range(0, 5))
      0:       return 8'd0;
      1:       return 8'($urandom_range(31, 33));
      2:       return 8'($urandom_range(1, 8));
      3:       return 8'(32 * $urandom_range(1, 7));
      4:       return 8'($urandom_range(0, 40));
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  // Launch one op on both units (called at a negedge); returns at the negedge dut1 shows done.
  task automatic run_op(input logic [1:0] op, input logic s, input logic [31:0] rm, input logic [7:0] amt,
                        input logic cin, input logic zin, input logic nin, input int inject_at);
    logic [31:0] e_rd;
    logic e_c, e_z, e_n;
    int cnt, cyc;
    int e_lat [2];
    bit got [2];
    model(op, s, rm, amt, cin, zin, nin, e_rd, e_c, e_z, e_n, cnt);
    e_lat[0] = 1 + cnt;
    e_lat[1] = 1 + (cnt + 3) / 4;
    drive(1'b1, op, s, rm, amt, cin, zin, nin);
    @(negedge clk);
    drive_junk(1'b0);
    cyc = 1; got[0] = 1'b0; got[1] = 1'b0;
    while (!(got[0] && got[1]) && cyc <= 60) begin
      if (cyc == 1) begin
        n_tests += 2;
        if (b1.busy !== (cnt > 0)) begin n_fail++; $display("FAIL busy_launch dut1: got %b expected %b", b1.busy, cnt > 0); end
        if (b4.busy !== (cnt > 0)) begin n_fail++; $display("FAIL busy_launch dut4: got %b expected %b", b4.busy, cnt > 0); end
      end
      if (!got[1] && b4.done === 1'b1) begin
        got[1] = 1'b1; o_lat[1] = cyc; o_rd[1] = b4.rd; o_c[1] = b4.carry_out; o_z[1] = b4.zero_out; o_n[1] = b4.neg_out;
      end else if (got[1]) begin
        n_tests++;
        if (b4.done !== 1'b0) begin n_fail++; $display("FAIL done_pulse dut4: got %b expected 0 at cycle %0d", b4.done, cyc); end
      end
      if (!got[0] && b1.done === 1'b1) begin
        got[0] = 1'b1; o_lat[0] = cyc; o_rd[0] = b1.rd; o_c[0] = b1.carry_out; o_z[0] = b1.zero_out; o_n[0] = b1.neg_out;
      end
      if (!(got[0] && got[1])) begin
        if (cyc == inject_at) begin
          n_tests += 2;
          if (b1.busy !== 1'b1) begin n_fail++; $display("FAIL inject_busy dut1: got %b expected 1", b1.busy); end
          if (b4.busy !== 1'b1) begin n_fail++; $display("FAIL inject_busy dut4: got %b expected 1", b4.busy); end
          drive_junk(1'b1);
        end else begin
          drive_junk(1'b0);
        end
        @(negedge clk);
        cyc++;
      end
    end
    drive_junk(1'b0);
    for (int d = 0; d < 2; d++) begin
      n_tests++;
      if (!got[d]) begin
        n_fail++; $display("FAIL timeout dut%0d: got no done, expected done within %0d cycles", d == 0 ? 1 : 4, e_lat[d]);
      end else begin
        n_tests += 4;
        if (o_lat[d] != e_lat[d]) begin n_fail++; $display("FAIL latency dut%0d op%0d amt%0d: got %0d expected %0d", d == 0 ? 1 : 4, op, amt, o_lat[d], e_lat[d]); end
        if (o_rd[d] !== e_rd) begin n_fail++; $display("FAIL rd dut%0d op%0d rm=%h amt%0d: got %h expected %h", d == 0 ? 1 : 4, op, rm, amt, o_rd[d], e_rd); end
        if (o_c[d] !== e_c) begin n_fail++; $display("FAIL carry dut%0d op%0d rm=%h amt%0d: got %b expected %b", d == 0 ? 1 : 4, op, rm, amt, o_c[d], e_c); end
        if ({o_z[d], o_n[d]} !== {e_z, e_n}) begin n_fail++; $display("FAIL zn dut%0d op%0d rm=%h amt%0d: got %b%b expected %b%b", d == 0 ? 1 : 4, op, rm, amt, o_z[d], o_n[d], e_z, e_n); end
      end
    end
  endtask

  task automatic test_reset();
    drive(1'b0, SH_LSL, 1'b0, 32'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({b1.busy, b1.done, b1.rd, b1.carry_out, b1.zero_out, b1.neg_out} !== 37'd0) begin
      n_fail++; $display("FAIL reset_hold dut1: got rd=%h busy=%b done=%b expected all 0", b1.rd, b1.busy, b1.done);
    end
    rst = 1'b0;
    @(negedge clk);
    n_tests += 2;
    if ({b1.busy, b1.done, b1.rd, b1.carry_out, b1.zero_out, b1.neg_out} !== 37'd0) begin
      n_fail++; $display("FAIL reset_release dut1: got rd=%h busy=%b done=%b expected all 0", b1.rd, b1.busy, b1.done);
    end
    if ({b4.busy, b4.done, b4.rd, b4.carry_out, b4.zero_out, b4.neg_out} !== 37'd0) begin
      n_fail++; $display("FAIL reset_release dut4: got rd=%h busy=%b done=%b expected all 0", b4.rd, b4.busy, b4.done);
    end
  endtask

  task automatic test_plan_vectors();
    run_op(SH_LSL, 1'b1, 32'h8000_0001, 8'd1, 1'b0, 1'b0, 1'b0, 0);
    n_tests++;
    if ({o_rd[0], o_c[0], o_z[0], o_n[0], 8'(o_lat[0])} !== {32'h0000_0002, 3'b100, 8'd2}) begin
      n_fail++; $display("FAIL plan_lsl1: got rd=%h c=%b lat=%0d expected 00000002 1 2", o_rd[0], o_c[0], o_lat[0]);
    end
    run_op(SH_ASR, 1'b1, 32'h8000_00F0, 8'd7, 1'b0, 1'b0, 1'b0, 0);
    n_tests++;
    if ({o_rd[1], o_c[1], o_n[1], 8'(o_lat[1])} !== {32'hFF00_0001, 2'b11, 8'd3}) begin
      n_fail++; $display("FAIL plan_asr7: got rd=%h c=%b lat=%0d expected ff000001 1 3", o_rd[1], o_c[1], o_lat[1]);
    end
    run_op(SH_LSR, 1'b1, 32'hFFFF_FFFF, 8'd32, 1'b0, 1'b0, 1'b0, 0);
    n_tests++;
    if ({o_rd[0], o_c[0], o_z[0]} !== {32'd0, 2'b11}) begin
      n_fail++; $display("FAIL plan_lsr32: got rd=%h c=%b z=%b expected 0 1 1", o_rd[0], o_c[0], o_z[0]);
    end
    run_op(SH_LSR, 1'b1, 32'hFFFF_FFFF, 8'd40, 1'b1, 1'b0, 1'b0, 0);
    n_tests++;
    if ({o_rd[0], o_c[0]} !== {32'd0, 1'b0}) begin
      n_fail++; $display("FAIL plan_lsr40: got rd=%h c=%b expected 0 0", o_rd[0], o_c[0]);
    end
    run_op(SH_LSL, 1'b1, 32'd0, 8'd0, 1'b1, 1'b0, 1'b0, 0);
    n_tests++;
    if ({o_rd[0], o_c[0], o_z[0], 8'(o_lat[0])} !== {32'd0, 2'b11, 8'd1}) begin
      n_fail++; $display("FAIL plan_amt0: got rd=%h c=%b z=%b lat=%0d expected 0 1 1 1", o_rd[0], o_c[0], o_z[0], o_lat[0]);
    end
    run_op(SH_ROR, 1'b1, 32'h0000_0001, 8'd1, 1'b0, 1'b0, 1'b0, 0);
    n_tests++;
`ifdef SHIFT_ROR_EN
    if ({o_rd[0], o_c[0], o_n[0]} !== {32'h8000_0000, 2'b11}) begin
      n_fail++; $display("FAIL plan_ror1: got rd=%h c=%b n=%b expected 80000000 1 1", o_rd[0], o_c[0], o_n[0]);
    end
`else
    if ({o_rd[0], o_c[0], o_z[0], o_n[0], 8'(o_lat[0])} !== {32'h0000_0001, 3'b000, 8'd1}) begin
      n_fail++; $display("FAIL plan_ror1_off: got rd=%h czn=%b%b%b lat=%0d expected 00000001 000 1", o_rd[0], o_c[0], o_z[0], o_n[0], o_lat[0]);
    end
`endif
    run_op(SH_ROR, 1'b1, 32'h8000_1234, 8'd64, 1'b0, 1'b1, 1'b0, 0);
    n_tests++;
`ifdef SHIFT_ROR_EN
    if ({o_rd[0], o_c[0]} !== {32'h8000_1234, 1'b1}) begin
      n_fail++; $display("FAIL plan_ror64: got rd=%h c=%b expected 80001234 1", o_rd[0], o_c[0]);
    end
`else
    if ({o_rd[0], o_c[0], o_z[0]} !== {32'h8000_1234, 2'b01}) begin
      n_fail++; $display("FAIL plan_ror64_off: got rd=%h c=%b z=%b expected 80001234 0 1", o_rd[0], o_c[0], o_z[0]);
    end
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 80; i++) begin
      run_op(2'($urandom), 1'($urandom), $urandom, pick_amt(), 1'($urandom), 1'($urandom), 1'($urandom), 0);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      n_tests++;
      if (b1.done !== 1'b1) begin n_fail++; $display("FAIL b2b_in_done dut1: got done=%b expected 1", b1.done); end
      run_op(2'($urandom_range(0, 2)), 1'b1, $urandom, 8'($urandom_range(1, 12)), 1'($urandom), 1'b0, 1'b0, 0);
    end
  endtask

  task automatic test_busy_ignore();
    run_op(SH_LSL, 1'b1, 32'h0001_2345, 8'd20, 1'b0, 1'b0, 1'b0, 2);
    run_op(SH_ASR, 1'b1, 32'h9000_0000, 8'd28, 1'b1, 1'b0, 1'b0, 5);
  endtask

  task automatic test_hold();
    logic [34:0] snap;
    bit bad_done;
    snap = {o_rd[0], o_c[0], o_z[0], o_n[0]};
    bad_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_junk(1'b0);
      @(negedge clk);
      if (b1.done !== 1'b0 || b4.done !== 1'b0) bad_done = 1'b1;
    end
    n_tests += 2;
    if (bad_done) begin n_fail++; $display("FAIL hold_done: got done pulse while idle expected none"); end
    if ({b1.rd, b1.carry_out, b1.zero_out, b1.neg_out} !== snap) begin
      n_fail++; $display("FAIL hold_rd dut1: got %h expected %h", {b1.rd, b1.carry_out, b1.zero_out, b1.neg_out}, snap);
    end
  endtask

  task automatic test_reset_mid();
    bit saw_done;
    drive(1'b1, SH_LSL, 1'b1, 32'hDEAD_BEEF, 8'd30, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    drive_junk(1'b0);
    repeat (2) @(negedge clk);
    n_tests += 2;
    if (b1.busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy dut1: got %b expected 1", b1.busy); end
    if (b4.busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy dut4: got %b expected 1", b4.busy); end
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    n_tests += 2;
    if ({b1.busy, b1.done, b1.rd, b1.carry_out, b1.zero_out, b1.neg_out} !== 37'd0) begin
      n_fail++; $display("FAIL mid_reset dut1: got rd=%h busy=%b expected all 0", b1.rd, b1.busy);
    end
    if ({b4.busy, b4.done, b4.rd, b4.carry_out, b4.zero_out, b4.neg_out} !== 37'd0) begin
      n_fail++; $display("FAIL mid_reset dut4: got rd=%h busy=%b expected all 0", b4.rd, b4.busy);
    end
    rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (b1.done !== 1'b0 || b4.done !== 1'b0 || b1.busy !== 1'b0) saw_done = 1'b1;
    end
    n_tests++;
    if (saw_done) begin n_fail++; $display("FAIL mid_abort: got activity after reset expected none"); end
  endtask

  initial begin
    test_reset();
    test_plan_vectors();
    test_random();
    test_back_to_back();
    test_hold();
    test_busy_ignore();
    test_reset_mid();
    run_op(SH_LSR, 1'b1, 32'h8000_0000, 8'd31, 1'b0, 1'b0, 1'b0, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
